zoom_win2x2_gen: RTL and testbench

Streaming 2x2 window generator feeding the zoom path's 2x2 average-pooling stage for HDMI 1920x1080 -> 960x540 downscale. Accepts a raster pixel stream of one 8-bit component, buffers one even source line in on-chip RAM, and emits one non-overlapping 2x2 window per odd-row/odd-column source pixel. Output is 960x540 windows per frame; the pooling stage consumes `pixel_1..pixel_4` directly.

---
 rtl/zoom_win2x2_gen.sv | 117 +++++++++++
 tb/tb_zoom_win2x2_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/zoom_win2x2_gen.sv
// Streaming 2x2 non-overlapping window generator for 2:1 zoom-down.
// One even source line is held as column pairs; each odd-row/odd-column pixel completes a window.
module zoom_win2x2_gen #(
    parameter int SRC_W = 1920,
    parameter int SRC_H = 1080,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sof,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    output logic          win_valid,
    output logic [DW-1:0] pixel_1,
    output logic [DW-1:0] pixel_2,
    output logic [DW-1:0] pixel_3,
    output logic [DW-1:0] pixel_4,
    output logic          win_sol,
    output logic          win_eof
);

    localparam int CW = $clog2(SRC_W);
    localparam int RW = $clog2(SRC_H);
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SRC_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SRC_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);

    logic [CW-1:0]   col_q, col_d, cur_col;
    logic [RW-1:0]   row_q, row_d, cur_row;
    logic [DW-1:0]   even_lat_q;
    logic [2*DW-1:0] line_mem [SRC_W/2];
    logic [2*DW-1:0] rd_q;
    logic [AW-1:0]   addr;
    logic            wr_en, rd_en, win_fire, lat_en;

    logic            win_valid_q, win_sol_q, win_eof_q;
    logic [DW-1:0]   pixel_1_q, pixel_2_q, pixel_3_q, pixel_4_q;

    // sof takes effect in its own cycle, so a coincident pixel is already (0,0).
    always_comb begin
        cur_col = sof ? '0 : col_q;
        cur_row = sof ? '0 : row_q;
        col_d   = cur_col;
        row_d   = cur_row;
        if (pix_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
            end
        end
    end

    assign addr     = cur_col[CW-1:1];
    assign lat_en   = pix_valid & ~cur_col[0];
    assign wr_en    = pix_valid & ~cur_row[0] &  cur_col[0];
    assign rd_en    = pix_valid &  cur_row[0] & ~cur_col[0];
    assign win_fire = pix_valid &  cur_row[0] &  cur_col[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            even_lat_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            col_q <= col_d;
            row_q <= row_d;
            if (lat_en)
                even_lat_q <= pix_data;
            else if (sof)
                even_lat_q <= '0;
        end
    end

    // NOTE: the line RAM and its read register are deliberately not reset; nothing reads a slot before this frame wrote it.
    always_ff @(posedge clk) begin
        if (wr_en)
            line_mem[addr] <= {pix_data, even_lat_q};
        if (rd_en)
            rd_q <= line_mem[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            win_sol_q   <= 1'b0;
            win_eof_q   <= 1'b0;
            pixel_1_q   <= '0;
            pixel_2_q   <= '0;
            pixel_3_q   <= '0;
            pixel_4_q   <= '0;
        end else begin
            win_valid_q <= win_fire;
            win_sol_q   <= win_fire && (cur_col == COL_ONE);
            win_eof_q   <= win_fire && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
            // Pixel outputs hold between windows.
            if (win_fire) begin
                pixel_1_q <= rd_q[DW-1:0];
                pixel_2_q <= rd_q[2*DW-1:DW];
                pixel_3_q <= even_lat_q;
                pixel_4_q <= pix_data;
            end
        end
    end

    assign win_valid = win_valid_q;
    assign win_sol   = win_sol_q;
    assign win_eof   = win_eof_q;
    assign pixel_1   = pixel_1_q;
    assign pixel_2   = pixel_2_q;
    assign pixel_3   = pixel_3_q;
    assign pixel_4   = pixel_4_q;

endmodule

// File: tb/tb_zoom_win2x2_gen.sv
// Scoreboard bench for zoom_win2x2_gen: a frame-image model predicts each window,
// an independent monitor compares every win_valid pulse against the queue.
module tb_zoom_win2x2_gen;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int WIN_PER_FRAME = (W / 2) * (H / 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          win_valid, win_sol, win_eof;
    logic [DW-1:0] pixel_1, pixel_2, pixel_3, pixel_4;

    zoom_win2x2_gen #(.SRC_W(W), .SRC_H(H), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sof       (sof),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .win_valid (win_valid),
        .pixel_1   (pixel_1),
        .pixel_2   (pixel_2),
        .pixel_3   (pixel_3),
        .pixel_4   (pixel_4),
        .win_sol   (win_sol),
        .win_eof   (win_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] p1, p2, p3, p4;
        logic          sol, eof;
        int            cyc;
    } win_t;

    win_t          exp_q[$];
    win_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            win_cnt = 0, sol_cnt = 0, eof_cnt = 0;
    logic [DW-1:0] img [H][W];
    int            m_row = 0, m_col = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid) begin
                win_cnt++;
                if (win_sol) sol_cnt++;
                if (win_eof) eof_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 64'(win_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("window_fields",
                          {28'd0, pixel_1, pixel_2, pixel_3, pixel_4, win_sol, win_eof},
                          {28'd0, mon_e.p1, mon_e.p2, mon_e.p3, mon_e.p4, mon_e.sol, mon_e.eof});
                    check("window_latency", 64'(cyc), 64'(mon_e.cyc));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                check("window_missing", 64'(win_valid), 64'd1);
            end
        end
    end

    function automatic logic [DW-1:0] pix_of(input int kind, input int r, input int c);
        case (kind)
            0:       pix_of = DW'(r * 16 + c);
            1:       pix_of = DW'(255 - (r * 16 + c));
            2:       pix_of = DW'(8'h80);
            default: pix_of = DW'($urandom);
        endcase
    endfunction

    // Sends one pixel after 'gap' idle cycles; the model stores it in the frame
    // image and predicts the window whenever an odd/odd position completes.
    task automatic send(input logic s, input int kind, input int gap);
        win_t w;
        logic [DW-1:0] d;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        if (s) begin
            m_row = 0;
            m_col = 0;
        end
        d = pix_of(kind, m_row, m_col);
        sof = s;
        pix_valid = 1'b1;
        pix_data = d;
        img[m_row][m_col] = d;
        if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
            w.p1  = img[m_row-1][m_col-1];
            w.p2  = img[m_row-1][m_col];
            w.p3  = img[m_row][m_col-1];
            w.p4  = d;
            w.sol = (m_col == 1);
            w.eof = (m_row == H - 1) && (m_col == W - 1);
            w.cyc = cyc + 1;
            exp_q.push_back(w);
        end
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row = (m_row + 1) % H;
        end
        @(posedge clk);
        #1;
        sof = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic send_pixels(input logic with_sof, input int kind, input int n, input int gapmax);
        for (int i = 0; i < n; i++)
            send(with_sof && (i == 0), kind, $urandom_range(gapmax, 0));
    endtask

    task automatic frame_and_count(input string name, input logic with_sof, input int kind, input int gapmax);
        int start;
        start = win_cnt;
        send_pixels(with_sof, kind, W * H, gapmax);
        repeat (3) @(posedge clk);
        #1;
        check(name, 64'(win_cnt - start), 64'(WIN_PER_FRAME));
    endtask

    initial begin
        int s_start, e_start;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {29'd0, win_valid, win_sol, win_eof, pixel_1, pixel_2, pixel_3, pixel_4}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp frame at full rate, then with random gaps, then inverted data.
        frame_and_count("count_ramp_full", 1'b1, 0, 0);
        frame_and_count("count_ramp_gaps", 1'b1, 0, 3);
        frame_and_count("count_inverted", 1'b1, 1, 0);

        // Abandon a frame at pixel (2,3): the sof pixel restarts at (0,0).
        send_pixels(1'b1, 0, 2 * W + 3, 1);
        frame_and_count("count_after_sof_mid", 1'b1, 0, 0);

        // Reset in an odd row right as a window pulses.
        send_pixels(1'b1, 3, W + 4, 0);
        check("pre_reset_valid", 64'(win_valid), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset_async_outputs",
              {29'd0, win_valid, win_sol, win_eof, pixel_1, pixel_2, pixel_3, pixel_4}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame_and_count("count_after_reset", 1'b1, 0, 1);

        // Constant frame: exact line-start and end-of-frame counts.
        s_start = sol_cnt;
        e_start = eof_cnt;
        frame_and_count("count_const", 1'b1, 2, 0);
        check("sol_count_const", 64'(sol_cnt - s_start), 64'(H / 2));
        check("eof_count_const", 64'(eof_cnt - e_start), 64'd1);

        // Counters wrap into an implicit new frame without sof.
        frame_and_count("count_implicit_wrap", 1'b0, 1, 2);
        frame_and_count("count_random_data", 1'b1, 3, 2);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
